// File: rtl/booth_r8_pkg.sv
// Shared types and helpers for the radix-8 Booth multiplier.
// Holds the FSM states, the digit-select encoding and the digit-count function.
package booth_r8_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StPre,
      StRun,
      StDone
   } state_e;

   typedef enum logic [2:0] {
      SelZero,
      SelM1,
      SelM2,
      SelM3,
      SelM4
   } sel_e;

   // Number of radix-8 digits: ceil((width + 1) / 3)
   function automatic int unsigned iter_f(input int unsigned width);
      return (width + 3) / 3;
   endfunction

endpackage

// File: rtl/booth_r8_digit.sv
// Radix-8 Booth digit decoder: maps {q[2:0], qneg} to a multiple magnitude and sign.
// Purely combinational.
module booth_r8_digit
   import booth_r8_pkg::*;
(
   input  logic [3:0] bits,
   output sel_e       sel,
   output logic       neg
);

   always_comb begin
      sel = SelZero;
      unique case (bits)
         4'b0000, 4'b1111:                   sel = SelZero;
         4'b0001, 4'b0010, 4'b1101, 4'b1110: sel = SelM1;
         4'b0011, 4'b0100, 4'b1011, 4'b1100: sel = SelM2;
         4'b0101, 4'b0110, 4'b1001, 4'b1010: sel = SelM3;
         4'b0111, 4'b1000:                   sel = SelM4;
      endcase
   end

   // 4'b1111 decodes to zero, which must not be negated
   assign neg = bits[3] & ~(&bits[2:0]);

endmodule

// File: rtl/booth_r8_mul.sv
// Sequential radix-8 Booth multiplier, one digit per cycle after a 3M precompute cycle.
// Define BOOTH_R8_UNSIGNED_EN to add the sgn port selecting signed/unsigned operands.
module booth_r8_mul
   import booth_r8_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
`ifdef BOOTH_R8_UNSIGNED_EN
   input  logic               sgn,
`endif
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int unsigned ITER = iter_f(WIDTH);
   localparam int unsigned QW   = 3 * ITER;
   localparam int unsigned MW   = WIDTH + 3;
   localparam int unsigned AW   = WIDTH + 4;
   localparam int unsigned CW   = $clog2(ITER);
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);

   state_e state_q, state_d;

   logic [MW-1:0]      m_q;
   logic [AW-1:0]      m3_q;
   logic [AW-1:0]      acc_q;
   logic [QW-1:0]      q_q;
   logic               qneg_q;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] product_q;

   logic               accept;
   logic               last;
   logic               sgn_ext;
   logic [QW-1:0]      x_ext;
   logic [MW-1:0]      y_ext;
   logic [AW-1:0]      m_ext, m2, m4;
   logic [AW-1:0]      mult, sum;
   logic [AW-1:0]      acc_nx;
   logic [QW-1:0]      q_nx;
   logic [2*WIDTH-1:0] product_d;
   sel_e               sel;
   logic               neg;

`ifdef BOOTH_R8_UNSIGNED_EN
   assign sgn_ext = sgn;
`else
   assign sgn_ext = 1'b1;
`endif

   assign accept = start & ((state_q == StIdle) | (state_q == StDone));
   assign last   = (cnt_q == LAST);

   assign x_ext = {{(QW - WIDTH){sgn_ext & x[WIDTH-1]}}, x};
   assign y_ext = {{3{sgn_ext & y[WIDTH-1]}}, y};

   // M carries three extension bits, so dropping its top bit for 4M loses nothing
   assign m_ext = {m_q[MW-1], m_q};
   assign m2    = {m_q, 1'b0};
   assign m4    = {m_q[MW-2:0], 2'b00};

   booth_r8_digit u_digit (
      .bits ({q_q[2:0], qneg_q}),
      .sel  (sel),
      .neg  (neg)
   );

   always_comb begin
      mult = '0;
      unique case (sel)
         SelZero: mult = '0;
         SelM1:   mult = m_ext;
         SelM2:   mult = m2;
         SelM3:   mult = m3_q;
         SelM4:   mult = m4;
         default: mult = '0;
      endcase
   end

   // Negative multiples: one's complement plus carry-in
   assign sum    = acc_q + (mult ^ {AW{neg}}) + {{(AW - 1){1'b0}}, neg};
   assign acc_nx = {{3{sum[AW-1]}}, sum[AW-1:3]};
   assign q_nx   = {sum[2:0], q_q[QW-1:3]};
   assign product_d = {acc_nx[2*WIDTH-QW-1:0], q_nx};

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StPre;
         StPre:   state_d = StRun;
         StRun:   if (last) state_d = StDone;
         StDone:  state_d = start ? StPre : StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      busy = (state_q == StPre) | (state_q == StRun);
      done = (state_q == StDone);
   end

   assign product = product_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         m_q       <= '0;
         m3_q      <= '0;
         acc_q     <= '0;
         q_q       <= '0;
         qneg_q    <= 1'b0;
         cnt_q     <= '0;
         product_q <= '0;
      end else if (accept) begin
         m_q    <= y_ext;
         q_q    <= x_ext;
         acc_q  <= '0;
         qneg_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         if (state_q == StPre) begin
            m3_q <= m_ext + m2;
         end
         if (state_q == StRun) begin
            acc_q  <= acc_nx;
            q_q    <= q_nx;
            qneg_q <= q_q[2];
            if (last) begin
               product_q <= product_d;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

endmodule
